// File: rtl/timer_ctrl.sv
// Run-control stage for the decimal countdown: debounced start/clear buttons,
// timer FSM, count enable gating and blink control for the expired display.
module timer_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20,
  parameter int BLINK_TICKS     = 5
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_btn_start_n,
  input  logic       i_btn_clear_n,
  input  logic       i_tick,
  input  logic       i_zero,
  output logic       o_init_vld,
  output logic       o_enable,
  output logic       o_blank,
  output logic [2:0] o_state
);

  localparam int NUM_BTN = 2;
  localparam int BL_W    = $clog2(BLINK_TICKS + 1);

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_IDLE    = 3'd1,
    S_RUN     = 3'd2,
    S_PAUSE   = 3'd3,
    S_EXPIRED = 3'd4
  } state_t;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;
  logic [1:0]         fill_q;

  assign btn_raw = {i_btn_clear_n, i_btn_start_n};

  // Synchronizer outputs are only trustworthy once the reset value has flushed.
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) fill_q <= '0;
    else        fill_q <= {fill_q[0], 1'b1};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    logic            sync1_q, sync2_q, stable_q, armed_q;
    logic [DB_W-1:0] cnt_q;
    logic            upd;

    assign upd      = (sync2_q != stable_q) && (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1));
    // A press only counts once the button has been seen released after reset.
    assign press[g] = upd & stable_q & armed_q;

    always_ff @(posedge CLK or negedge rst_n)
      if (!rst_n) begin
        sync1_q  <= 1'b1;
        sync2_q  <= 1'b1;
        stable_q <= 1'b1;
        armed_q  <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync1_q <= btn_raw[g];
        sync2_q <= sync1_q;
        if (sync2_q == stable_q) begin
          cnt_q <= '0;
        end else if (upd) begin
          cnt_q    <= '0;
          stable_q <= sync2_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        if (fill_q[1] && sync2_q && stable_q) armed_q <= 1'b1;
      end
  end

  logic start_p, clear_p;
  assign start_p = press[0];
  assign clear_p = press[1];

  state_t          state_q, state_d;
  logic [BL_W-1:0] blink_q, blink_d;
  logic            blank_q, blank_d;

  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_LOAD;
      blink_q <= '0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      blink_q <= blink_d;
      blank_q <= blank_d;
    end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:    state_d = S_IDLE;
      S_IDLE:    if (clear_p) state_d = S_LOAD;
                 else if (start_p) state_d = S_RUN;
      S_RUN:     if (clear_p) state_d = S_LOAD;
                 else if (start_p) state_d = S_PAUSE;
                 else if (i_zero) state_d = S_EXPIRED;
      S_PAUSE:   if (clear_p) state_d = S_LOAD;
                 else if (start_p) state_d = S_RUN;
      S_EXPIRED: if (clear_p || start_p) state_d = S_LOAD;
      default:   state_d = S_LOAD;
    endcase
  end

  // Blink state is cleared whenever the next state is not EXPIRED, so it
  // always starts fresh on entry and never leaks into LOAD.
  always_comb begin
    blink_d = blink_q;
    blank_d = blank_q;
    if (state_d != S_EXPIRED) begin
      blink_d = '0;
      blank_d = 1'b0;
    end else if (state_q == S_EXPIRED && i_tick) begin
      if (blink_q == BL_W'(BLINK_TICKS - 1)) begin
        blink_d = '0;
        blank_d = ~blank_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end
  end

  assign o_init_vld = (state_q == S_LOAD);
  assign o_enable   = (state_q == S_RUN) & i_tick & ~i_zero;
  assign o_blank    = blank_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: vector table for the scripted scenarios, hand-written
// async-reset sequences and a random phase, all against a window-based model.
module tb_timer_ctrl;
  localparam int D  = 4;
  localparam int BT = 2;

  logic       CLK, rst_n;
  logic       btn_s, btn_c, btn_t, btn_z;
  logic       o_init_vld, o_enable, o_blank;
  logic [2:0] o_state;

  timer_ctrl #(.DEBOUNCE_CYCLES(D), .DB_W(3), .BLINK_TICKS(BT)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .i_btn_start_n(btn_s), .i_btn_clear_n(btn_c),
    .i_tick(btn_t), .i_zero(btn_z),
    .o_init_vld(o_init_vld), .o_enable(o_enable),
    .o_blank(o_blank), .o_state(o_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // reference model: raw button history per edge, debounce as a stability window
  bit hist [2][64];
  int m_edge;
  int m_last [2];
  bit m_stable [2];
  bit m_armed [2];
  int m_state;
  int m_n;
  bit m_blank;

  typedef struct {
    logic s_n, c_n, tick, zero;
    int   cycles;
    int   st;
    logic en, init, blank;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edge = 0; m_state = 0; m_n = 0; m_blank = 0;
    for (int b = 0; b < 2; b++) begin
      m_last[b] = 0; m_stable[b] = 1; m_armed[b] = 0;
      hist[b][0] = 1; hist[b][63] = 1;
    end
  endtask

  task automatic model_edge();
    bit raw [2];
    bit press [2];
    int old;
    raw[0] = btn_s; raw[1] = btn_c;
    m_edge++;
    for (int b = 0; b < 2; b++) begin
      bit s, upd;
      hist[b][m_edge & 63] = raw[b];
      s   = hist[b][(m_edge - 2) & 63];
      upd = 1;
      for (int j = 0; j < D; j++) begin
        int x;
        x = m_edge - j;
        if (x <= m_last[b] || hist[b][(x - 2) & 63] == m_stable[b]) upd = 0;
      end
      press[b] = upd && m_armed[b] && m_stable[b] && !s;
      if (m_edge >= 3 && s && m_stable[b]) m_armed[b] = 1;
      if (upd) begin m_stable[b] = s; m_last[b] = m_edge; end
    end
    old = m_state;
    case (old)
      0: m_state = 1;
      1: if (press[1]) m_state = 0; else if (press[0]) m_state = 2;
      2: if (press[1]) m_state = 0; else if (press[0]) m_state = 3; else if (btn_z) m_state = 4;
      3: if (press[1]) m_state = 0; else if (press[0]) m_state = 2;
      4: if (press[0] || press[1]) m_state = 0;
      default: m_state = 0;
    endcase
    if (m_state != 4) m_n = 0;
    else if (old == 4 && btn_t) m_n++;
    m_blank = ((m_n / BT) % 2) == 1;
  endtask

  // drive one cycle's inputs, then compare against the model at the falling edge
  task automatic drive_check(input logic s, input logic c, input logic t, input logic z);
    btn_s = s; btn_c = c; btn_t = t; btn_z = z;
    @(negedge CLK);
    chk("model_state", o_state, m_state);
    chk("model_enable", o_enable, (m_state == 2) && t && !z);
    chk("model_init", o_init_vld, m_state == 0);
    chk("model_blank", o_blank, m_blank);
  endtask

  task automatic finish_cycle();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic cyc(input logic s, input logic c, input logic t, input logic z, input int n);
    for (int i = 0; i < n; i++) begin
      drive_check(s, c, t, z);
      finish_cycle();
    end
  endtask

  task automatic add(input logic s, input logic c, input logic t, input logic z, input int n,
                     input int st, input logic en, input logic init, input logic blank);
    vec_t v;
    v.s_n = s; v.c_n = c; v.tick = t; v.zero = z; v.cycles = n;
    v.st = st; v.en = en; v.init = init; v.blank = blank;
    tbl.push_back(v);
  endtask

  initial begin
    // reset / LOAD lasts one cycle
    add(1,1,0,0, 1, 0,0,1,0);
    add(1,1,0,0, 1, 1,0,0,0);
    add(1,1,1,0, 2, 1,0,0,0);
    // bouncing start gives no press; held low gives exactly one
    for (int i = 0; i < 5; i++) begin
      add(0,1,0,0, 2, 1,0,0,0);
      add(1,1,0,0, 2, 1,0,0,0);
    end
    add(0,1,0,0, 12, 2,0,0,0);
    add(0,1,1,0, 1, 2,1,0,0);
    add(1,1,0,0, 6, 2,0,0,0);
    add(1,1,1,0, 1, 2,1,0,0);
    // pause: press lands on a tick cycle, tick still passes
    add(0,1,0,0, 5, 2,0,0,0);
    add(0,1,1,0, 1, 2,1,0,0);
    add(0,1,0,0, 1, 3,0,0,0);
    add(1,1,1,0, 5, 3,0,0,0);
    add(1,1,0,0, 4, 3,0,0,0);
    add(0,1,0,0, 7, 2,0,0,0);
    add(1,1,0,0, 6, 2,0,0,0);
    // expiry and blink
    add(1,1,1,1, 1, 2,0,0,0);
    add(1,1,0,1, 1, 4,0,0,0);
    add(1,1,1,1, 1, 4,0,0,0);
    add(1,1,0,1, 1, 4,0,0,0);
    add(1,1,1,1, 1, 4,0,0,0);
    add(1,1,0,1, 1, 4,0,0,1);
    add(1,1,1,1, 1, 4,0,0,1);
    add(1,1,0,1, 1, 4,0,0,1);
    add(1,1,1,1, 1, 4,0,0,1);
    add(1,1,0,1, 1, 4,0,0,0);
    add(1,0,0,1, 7, 0,0,1,0);
    add(1,0,0,0, 1, 1,0,0,0);
    add(1,1,0,0, 6, 1,0,0,0);
    // start and clear together in PAUSE: clear wins
    add(0,1,0,0, 7, 2,0,0,0);
    add(1,1,0,0, 6, 2,0,0,0);
    add(0,1,0,0, 7, 3,0,0,0);
    add(1,1,0,0, 6, 3,0,0,0);
    add(0,0,0,0, 7, 0,0,1,0);
    add(0,0,0,0, 1, 1,0,0,0);
    add(1,1,0,0, 6, 1,0,0,0);
    // start from IDLE already at zero: one RUN cycle then EXPIRED
    add(0,1,0,1, 7, 2,0,0,0);
    add(0,1,0,1, 1, 4,0,0,0);
    add(1,1,0,1, 6, 4,0,0,0);
    add(1,0,0,0, 7, 0,0,1,0);
    add(1,1,0,0, 7, 1,0,0,0);

    btn_s = 1; btn_c = 1; btn_t = 0; btn_z = 0;
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1 rst_n = 1;

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].cycles; k++) begin
        drive_check(tbl[i].s_n, tbl[i].c_n, tbl[i].tick, tbl[i].zero);
        if (k == tbl[i].cycles - 1) begin
          chk($sformatf("vec%0d_state", i), o_state, tbl[i].st);
          chk($sformatf("vec%0d_enable", i), o_enable, tbl[i].en);
          chk($sformatf("vec%0d_init", i), o_init_vld, tbl[i].init);
          chk($sformatf("vec%0d_blank", i), o_blank, tbl[i].blank);
        end
        finish_cycle();
      end
    end

    // async reset mid-RUN, with start still held through reset
    cyc(0,1,0,0, 7);
    drive_check(0,1,1,0);
    chk("pre_rst_enable", o_enable, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_state", o_state, 0);
    chk("async_rst_enable", o_enable, 0);
    chk("async_rst_blank", o_blank, 0);
    chk("async_rst_init", o_init_vld, 1);
    model_reset();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    rst_n = 1;
    cyc(0,1,0,0, 15);
    chk("held_start_no_press", o_state, 1);
    cyc(1,1,0,0, 6);
    cyc(0,1,0,0, 7);
    chk("repress_after_reset", o_state, 2);
    cyc(1,1,0,0, 6);

    // random phase
    begin
      logic s, c, z;
      s = 1; c = 1; z = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(9) == 0)  s = ~s;
        if ($urandom_range(24) == 0) c = ~c;
        if ($urandom_range(19) == 0) z = ~z;
        cyc(s, c, ($urandom_range(2) == 0), z, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
